// File: rtl/mem_arb2.sv
// Two-port round-robin memory arbiter with in-order read return routing.
// Read credit is bounded by OUTST; writes bypass the tag FIFO entirely.
module mem_arb2 #(
    parameter int MEM_AW = 16,
    parameter int MEM_DW = 32,
    parameter int OUTST  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        rq_req,
    input  logic              rq0_write,
    input  logic              rq1_write,
    input  logic [MEM_AW-1:0] rq0_addr,
    input  logic [MEM_AW-1:0] rq1_addr,
    input  logic [MEM_DW-1:0] rq0_wdata,
    input  logic [MEM_DW-1:0] rq1_wdata,
    output logic [1:0]        rq_gnt,
    output logic [1:0]        rq_rdata_vld,
    output logic [MEM_DW-1:0] rq_rdata,
    output logic              mem_req,
    output logic              mem_write,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [MEM_DW-1:0] mem_wdata,
    input  logic              mem_rdata_vld,
    input  logic [MEM_DW-1:0] mem_rdata,
    output logic              err
);
    localparam int PW = $clog2(OUTST);
    localparam int CW = $clog2(OUTST + 1);

    logic [CW-1:0]     inflight;
    logic [PW-1:0]     wrPtr;
    logic [PW-1:0]     rdPtr;
    logic [OUTST-1:0]  tagMem;
    logic              prio;
    logic [1:0]        elig;
    logic [1:0]        gnt;
    logic              gntWrite;
    logic [MEM_AW-1:0] gntAddr;
    logic [MEM_DW-1:0] gntWdata;
    logic              push;
    logic              pop;
    logic              empty;
    logic              full;

    assign empty = (inflight == '0);
    assign full  = (inflight == CW'(OUTST));

    assign elig[0] = rq_req[0] & (rq0_write | ~full);
    assign elig[1] = rq_req[1] & (rq1_write | ~full);

    // prio names the port that wins a tie
    always_comb begin
        gnt = 2'b00;
        if (rst_n) begin
            unique case (elig)
                2'b11:   gnt = prio ? 2'b10 : 2'b01;
                default: gnt = elig;
            endcase
        end
    end

    assign rq_gnt   = gnt;
    assign gntWrite = gnt[1] ? rq1_write : rq0_write;
    assign gntAddr  = gnt[1] ? rq1_addr  : rq0_addr;
    assign gntWdata = gnt[1] ? rq1_wdata : rq0_wdata;

    assign push = (|gnt) & ~gntWrite;
    assign pop  = rst_n & mem_rdata_vld & ~empty;

    always_comb begin
        rq_rdata_vld = 2'b00;
        if (pop) begin
            rq_rdata_vld = tagMem[rdPtr] ? 2'b10 : 2'b01;
        end
    end

    assign rq_rdata = mem_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            inflight  <= '0;
            wrPtr     <= '0;
            rdPtr     <= '0;
            prio      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_req <= |gnt;
            if (|gnt) begin
                mem_write <= gntWrite;
                mem_addr  <= gntAddr;
                mem_wdata <= gntWdata;
                prio      <= gnt[0];
            end
            if (push) begin
                tagMem[wrPtr] <= gnt[1];
                wrPtr         <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            inflight <= inflight + CW'(push) - CW'(pop);
            if (mem_rdata_vld && empty) begin
                err <= 1'b1;
            end
        end
    end
endmodule
